lap_apb_regfile: RTL and testbench

Ten-entry lap-time register file sitting directly downstream of the stopwatch core. It captures each stored lap word (packed `{hour, min, sec, sub_sec}`) and its slot address, and tracks which slots hold data. It exposes the laps, status and an interrupt to the CPU through a zero-wait-state APB slave.

---
 rtl/lap_apb_regfile.sv | 185 ++++++++++++++++++
 tb/tb_lap_apb_regfile.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lap_apb_regfile.sv
// lap_apb_regfile: lap-time register file downstream of the stopwatch core.
// Captures lap words into slots, tracks valid slots, count, last slot and
// overflow, and exposes everything plus an interrupt through a zero-wait APB slave.
module lap_apb_regfile #(
  parameter int NUM_LAPS = 10,
  parameter int LAP_W    = 26
) (
  input  logic             iPCLK,
  input  logic             iRESET,
  input  logic             lap_wr,
  input  logic [LAP_W-1:0] lap,
  input  logic [3:0]       lap_addr,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [7:0]       PADDR,
  input  logic [31:0]      PWDATA,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  output logic             oIRQ
);

  // Word addresses of the control/status registers; LAPn occupy words 0..NUM_LAPS-1.
  localparam logic [5:0] STATUS_W = 6'd10;
  localparam logic [5:0] CTRL_W   = 6'd11;
  localparam logic [5:0] INT_W    = 6'd12;

  logic [5:0]          word;
  logic                apb_setup;
  logic                apb_access;
  logic                addr_err;
  logic                ro_err;
  logic                xfer_err;
  logic                wr_ok;
  logic                ctrl_clr;
  logic                int_wr;
  logic                cap;
  logic                bad_lap;
  logic                new_slot;

  logic [NUM_LAPS-1:0] slot_hit;
  logic [LAP_W-1:0]    lap_q [NUM_LAPS];

  logic [NUM_LAPS-1:0] valid_reg, valid_base, valid_next;
  logic [3:0]          count_reg, count_base, count_next;
  logic [3:0]          last_reg, last_base, last_next;
  logic                ovf_reg, ovf_base, ovf_next;
  logic                pend_reg, pend_next;
  logic                en_reg, en_next;
  logic                irq_reg;
  logic [31:0]         prdata_reg;
  logic                pslverr_reg;
  logic [31:0]         status_word;
  logic [31:0]         rdata_next;

  assign word       = PADDR[7:2];
  assign apb_setup  = PSEL & ~PENABLE;
  assign apb_access = PSEL & PENABLE;

  // Anything past INT is unmapped; LAPn and STATUS are read-only.
  assign addr_err = (word > INT_W);
  assign ro_err   = PWRITE & (word <= STATUS_W);
  assign xfer_err = addr_err | ro_err;

  // Writes commit on the access-phase edge and only when the transfer is legal.
  assign wr_ok    = apb_access & PWRITE & ~xfer_err;
  assign ctrl_clr = wr_ok & (word == CTRL_W) & PWDATA[0];
  assign int_wr   = wr_ok & (word == INT_W);

  assign cap     = lap_wr & (lap_addr < 4'(NUM_LAPS));
  assign bad_lap = lap_wr & ~cap;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LAPS; gi++) begin : g_slot
      logic [LAP_W-1:0] lap_reg;

      assign slot_hit[gi] = cap & (lap_addr == 4'(gi));
      assign lap_q[gi]    = lap_reg;

      // Per-slot lap storage; CTRL clear deliberately leaves the data alone.
      always_ff @(posedge iPCLK) begin
        if (iRESET) begin
          lap_reg <= '0;
        end else if (slot_hit[gi]) begin
          lap_reg <= lap;
        end
      end
    end
  endgenerate

  // Bookkeeping next-state: the CTRL clear is applied first, then any capture on top.
  always_comb begin
    valid_base = ctrl_clr ? '0   : valid_reg;
    count_base = ctrl_clr ? 4'd0 : count_reg;
    last_base  = ctrl_clr ? 4'd0 : last_reg;
    ovf_base   = ctrl_clr ? 1'b0 : ovf_reg;

    new_slot   = |(slot_hit & ~valid_base);
    valid_next = valid_base | slot_hit;
    count_next = count_base + {3'b000, new_slot};
    last_next  = cap ? lap_addr : last_base;
    ovf_next   = ovf_base | bad_lap;

    // W1C first so that a same-edge capture keeps pending set.
    pend_next = pend_reg;
    en_next   = en_reg;
    if (int_wr) begin
      en_next = PWDATA[1];
      if (PWDATA[0]) begin
        pend_next = 1'b0;
      end
    end
    if (cap) begin
      pend_next = 1'b1;
    end
  end

  // Status/interrupt state registers.
  always_ff @(posedge iPCLK) begin
    if (iRESET) begin
      valid_reg <= '0;
      count_reg <= 4'd0;
      last_reg  <= 4'd0;
      ovf_reg   <= 1'b0;
      pend_reg  <= 1'b0;
      en_reg    <= 1'b0;
      irq_reg   <= 1'b0;
    end else begin
      valid_reg <= valid_next;
      count_reg <= count_next;
      last_reg  <= last_next;
      ovf_reg   <= ovf_next;
      pend_reg  <= pend_next;
      en_reg    <= en_next;
      irq_reg   <= pend_reg & en_reg;
    end
  end

  // Assemble STATUS: valid mask, count, last slot, sticky overflow.
  always_comb begin
    status_word                 = '0;
    status_word[NUM_LAPS-1:0]   = valid_reg;
    status_word[19:16]          = count_reg;
    status_word[23:20]          = last_reg;
    status_word[24]             = ovf_reg;
  end

  // Read mux on current state; CTRL and unmapped addresses read as zero.
  always_comb begin
    rdata_next = '0;
    for (int i = 0; i < NUM_LAPS; i++) begin
      if (word == 6'(i)) begin
        rdata_next = 32'(lap_q[i]);
      end
    end
    if (word == STATUS_W) begin
      rdata_next = status_word;
    end
    if (word == INT_W) begin
      rdata_next = {30'd0, en_reg, pend_reg};
    end
  end

  // Read data loads on the setup edge and holds until the next read setup;
  // the error flag is also decided at setup so it is stable across the access phase.
  always_ff @(posedge iPCLK) begin
    if (iRESET) begin
      prdata_reg  <= '0;
      pslverr_reg <= 1'b0;
    end else begin
      if (apb_setup & ~PWRITE) begin
        prdata_reg <= rdata_next;
      end
      pslverr_reg <= apb_setup & xfer_err;
    end
  end

  assign PRDATA  = prdata_reg;
  assign PREADY  = 1'b1;
  assign PSLVERR = pslverr_reg;
  assign oIRQ    = irq_reg;

endmodule

// File: tb/tb_lap_apb_regfile.sv
// Testbench for lap_apb_regfile: APB stimulus pushes expected responses into a
// queue; a monitor pops and checks them in every access phase.
module tb_lap_apb_regfile;

  logic        iPCLK = 1'b0;
  logic        iRESET = 1'b1;
  logic        lap_wr = 1'b0;
  logic [25:0] lap = '0;
  logic [3:0]  lap_addr = '0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [7:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        oIRQ;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;
    logic        chk_d;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  lap_apb_regfile #(.NUM_LAPS(10), .LAP_W(26)) dut (
    .iPCLK(iPCLK), .iRESET(iRESET), .lap_wr(lap_wr), .lap(lap), .lap_addr(lap_addr),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .oIRQ(oIRQ)
  );

  always #5 iPCLK = ~iPCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Monitor: every access phase pops one expected response.
  always @(negedge iPCLK) begin
    if (PSEL && PENABLE) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected access addr 0x%02h: got no expectation, required one", PADDR);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("%s 0x%02h pslverr", e.w ? "wr" : "rd", e.a), 32'(PSLVERR), 32'(e.err));
        check($sformatf("pready 0x%02h", e.a), 32'(PREADY), 32'd1);
        if (!e.w && e.chk_d) begin
          check($sformatf("rd 0x%02h data", e.a), PRDATA, e.d);
        end
      end
    end
  end

  // One APB transfer; optionally a lap strobe lands on the access edge.
  task automatic apb(input logic w, input logic [7:0] a, input logic [31:0] d,
                     input logic chk_d, input logic err,
                     input logic with_lap, input logic [3:0] la, input logic [25:0] lv);
    exp_t e;
    e.w = w; e.a = a; e.d = d; e.chk_d = chk_d; e.err = err;
    exp_q.push_back(e);
    @(posedge iPCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = w ? d : 32'd0;
    @(posedge iPCLK); #1;
    PENABLE = 1'b1;
    if (with_lap) begin
      lap_wr = 1'b1; lap_addr = la; lap = lv;
    end
    @(posedge iPCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    lap_wr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] d);
    apb(1'b0, a, d, 1'b1, 1'b0, 1'b0, 4'd0, 26'd0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic err);
    apb(1'b1, a, d, 1'b0, err, 1'b0, 4'd0, 26'd0);
  endtask

  // Single lap strobe; returns 1ns after the capturing edge.
  task automatic strobe(input logic [3:0] la, input logic [25:0] lv);
    @(posedge iPCLK); #1;
    lap_wr = 1'b1; lap_addr = la; lap = lv;
    @(posedge iPCLK); #1;
    lap_wr = 1'b0;
  endtask

  function automatic logic [25:0] vslot(input int i);
    return 26'(i * 26'h12345 + 1);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then read everything back as zero.
    repeat (3) @(posedge iPCLK);
    #1 iRESET = 1'b0;
    check("reset PRDATA", PRDATA, 32'd0);
    check("reset PSLVERR", 32'(PSLVERR), 32'd0);
    check("reset oIRQ", 32'(oIRQ), 32'd0);
    for (int i = 0; i < 10; i++) rd(8'(4 * i), 32'd0);
    rd(8'h28, 32'd0);
    rd(8'h2C, 32'd0);
    rd(8'h30, 32'd0);
    apb(1'b0, 8'h34, 32'd0, 1'b0, 1'b1, 1'b0, 4'd0, 26'd0);

    // Capture and read back with IRQ enabled.
    wr(8'h30, 32'h2, 1'b0);
    strobe(4'd3, 26'h0841AD);
    check("irq at capture edge", 32'(oIRQ), 32'd0);
    @(posedge iPCLK); #1;
    check("irq one cycle after capture", 32'(oIRQ), 32'd1);
    rd(8'h0C, 32'h0008_41AD);
    rd(8'h28, 32'h0031_0008);
    rd(8'h30, 32'h0000_0003);

    // Back-to-back strobes into all slots, then overwrite slot 0.
    @(posedge iPCLK); #1;
    lap_wr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      lap_addr = 4'(i); lap = vslot(i);
      @(posedge iPCLK); #1;
    end
    lap_addr = 4'd0; lap = 26'h2ABCDEF;
    @(posedge iPCLK); #1;
    lap_wr = 1'b0;
    rd(8'h28, 32'h000A_03FF);
    rd(8'h00, 32'h02AB_CDEF);
    rd(8'h24, 32'(vslot(9)));
    rd(8'h14, 32'(vslot(5)));

    // Out-of-range slot: only overflow changes, pending stays clear.
    wr(8'h30, 32'h3, 1'b0);
    strobe(4'd12, 26'h3FFFFFF);
    @(posedge iPCLK); #1;
    check("irq after out-of-range strobe", 32'(oIRQ), 32'd0);
    rd(8'h28, 32'h010A_03FF);
    rd(8'h30, 32'h0000_0002);

    // CTRL clear colliding with a capture to slot 5.
    apb(1'b1, 8'h2C, 32'h1, 1'b0, 1'b0, 1'b1, 4'd5, 26'h1234567);
    rd(8'h28, 32'h0051_0020);
    rd(8'h30, 32'h0000_0003);
    rd(8'h14, 32'h0123_4567);
    rd(8'h00, 32'h02AB_CDEF);

    // Illegal writes have no effect; CTRL read is legal.
    wr(8'h28, 32'hFFFF_FFFF, 1'b1);
    wr(8'h08, 32'hFFFF_FFFF, 1'b1);
    wr(8'h40, 32'hFFFF_FFFF, 1'b1);
    rd(8'h28, 32'h0051_0020);
    rd(8'h08, 32'(vslot(2)));
    rd(8'h2C, 32'd0);

    // W1C pending: oIRQ drops one cycle after the access edge.
    check("irq before W1C", 32'(oIRQ), 32'd1);
    wr(8'h30, 32'h3, 1'b0);
    check("irq at W1C edge", 32'(oIRQ), 32'd1);
    @(posedge iPCLK); #1;
    check("irq one cycle after W1C", 32'(oIRQ), 32'd0);

    // W1C on the same edge as a capture: set wins.
    apb(1'b1, 8'h30, 32'h3, 1'b0, 1'b0, 1'b1, 4'd7, 26'h0000042);
    rd(8'h30, 32'h0000_0003);

    repeat (3) @(posedge iPCLK);
    #1;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
